// File: rtl/fsign_pipe.sv
// Pipelined sign-injection unit (FSGNJ/FSGNJN/FSGNJX/FABS/FNEG/FMV) with
// valid/ready on both sides, bubble collapsing, flush and a passthrough tag.
package fsign_pkg;
    typedef enum logic [2:0] {
        OP_SGNJ  = 3'b000,
        OP_SGNJN = 3'b001,
        OP_SGNJX = 3'b010,
        OP_ABS   = 3'b011,
        OP_NEG   = 3'b100,
        OP_MOV   = 3'b101,
        OP_RSV6  = 3'b110,
        OP_RSV7  = 3'b111
    } op_e;
endpackage

module fsign_pipe
    import fsign_pkg::*;
#(
    parameter int FLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAGW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [FLEN-1:0] in_x1,
    input  logic [FLEN-1:0] in_x2,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FLEN-1:0] out_y,
    output logic [TAGW-1:0] out_tag,
    output logic            out_illegal
);

    localparam int S = FLEN - 1;

    typedef struct packed {
        logic [FLEN-1:0] y;
        logic [TAGW-1:0] tag;
        logic            illegal;
    } payload_t;

    payload_t              stage_in;
    logic     [STAGES-1:0] valid_q;
    logic     [STAGES-1:0] valid_d;
    payload_t              data_q [STAGES];
    payload_t              data_d [STAGES];
    logic     [STAGES-1:0] adv;
    logic                  all_full;
    logic                  accept;

    // The magnitude is always x1; only the sign bit is replaced.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        stage_in.y       = in_x1;
        stage_in.tag     = in_tag;
        stage_in.illegal = 1'b0;
        case (op_e'(in_op))
            OP_SGNJ:  stage_in.y[S] = in_x2[S];
            OP_SGNJN: stage_in.y[S] = ~in_x2[S];
            OP_SGNJX: stage_in.y[S] = in_x1[S] ^ in_x2[S];
            OP_ABS:   stage_in.y[S] = 1'b0;
            OP_NEG:   stage_in.y[S] = ~in_x1[S];
            OP_MOV:   ;
            default:  stage_in.illegal = 1'b1;
        endcase
    end

    // A stage can move unless it and every stage after it are full and the
    // consumer is stalling; this lets bubbles collapse.
    always_comb begin
        all_full = 1'b1;
        adv      = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            all_full = all_full & valid_q[i];
            adv[i]   = out_ready | ~all_full;
        end
    end

    assign in_ready = adv[0] & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (adv[0]) begin
            valid_d[0] = accept;
            if (accept) data_d[0] = stage_in;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (adv[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) data_d[i] = data_q[i-1];
            end
        end
        if (flush) valid_d = '0;
    end

    // NOTE: state is updated with non-blocking assignments so every stage
    // samples its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            // NOTE: the data registers are reset too, because the outputs
            // must read as zero after reset rather than as stale contents.
            for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid   = valid_q[STAGES-1];
    assign out_y       = data_q[STAGES-1].y;
    assign out_tag     = data_q[STAGES-1].tag;
    assign out_illegal = data_q[STAGES-1].illegal;

endmodule

// File: tb/tb_fsign_pipe.sv
// Bench for fsign_pipe: four instances (32b/1, 32b/2, 32b/3, 64b/4 stages) on
// shared inputs, directed scenarios plus a randomized scoreboard run.
module tb_fsign_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  in_op;
    logic [63:0] in_x1;
    logic [63:0] in_x2;
    logic [4:0]  in_tag;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_y;
    logic [4:0]  a_out_tag;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [31:0] b_out_y;
    logic [4:0]  b_out_tag;
    logic        c_in_ready, c_out_valid, c_out_illegal;
    logic [31:0] c_out_y;
    logic [4:0]  c_out_tag;
    logic        w_in_ready, w_out_valid, w_out_illegal;
    logic [63:0] w_out_y;
    logic [4:0]  w_out_tag;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fsign_pipe #(.FLEN(32), .STAGES(1), .TAGW(5)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_op(in_op), .in_x1(in_x1[31:0]), .in_x2(in_x2[31:0]), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_y(a_out_y),
        .out_tag(a_out_tag), .out_illegal(a_out_illegal));

    fsign_pipe #(.FLEN(32), .STAGES(2), .TAGW(5)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_op(in_op), .in_x1(in_x1[31:0]), .in_x2(in_x2[31:0]), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_y(b_out_y),
        .out_tag(b_out_tag), .out_illegal(b_out_illegal));

    fsign_pipe #(.FLEN(32), .STAGES(3), .TAGW(5)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_op(in_op), .in_x1(in_x1[31:0]), .in_x2(in_x2[31:0]), .in_tag(in_tag),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_y(c_out_y),
        .out_tag(c_out_tag), .out_illegal(c_out_illegal));

    fsign_pipe #(.FLEN(64), .STAGES(4), .TAGW(5)) u_w (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_op(in_op), .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_y(w_out_y),
        .out_tag(w_out_tag), .out_illegal(w_out_illegal));

    // Reference: returns {illegal, y} using arithmetic on the sign position.
    function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [63:0] x1,
                                           input logic [63:0] x2, input int flen);
        logic [63:0] top, mag;
        logic        s1, s2, s, ill;
        top = 64'd1 << (flen - 1);
        mag = x1 & (top - 64'd1);
        s1  = (x1 & top) != 64'd0;
        s2  = (x2 & top) != 64'd0;
        ill = 1'b0;
        case (op)
            3'd0:    s = s2;
            3'd1:    s = !s2;
            3'd2:    s = s1 ^ s2;
            3'd3:    s = 1'b0;
            3'd4:    s = !s1;
            3'd5:    s = s1;
            default: begin s = s1; ill = 1'b1; end
        endcase
        return {ill, (s ? top : 64'd0) | mag};
    endfunction

    task automatic idle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_op     = 3'd0;
        in_x1     = 64'd0;
        in_x2     = 64'd0;
        in_tag    = 5'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({a_out_valid, a_out_y, a_out_tag, a_out_illegal, a_in_ready} !== {1'b0, 32'h0, 5'h0, 1'b0, 1'b1})
            $display("FAIL reset_a: got v=%b y=%h t=%h il=%b rdy=%b expected 0/0/0/0/1",
                     a_out_valid, a_out_y, a_out_tag, a_out_illegal, a_in_ready);
        else n_pass++;
        n_checks++;
        if ({b_out_valid, b_out_y, b_out_tag, b_out_illegal, b_in_ready} !== {1'b0, 32'h0, 5'h0, 1'b0, 1'b1})
            $display("FAIL reset_b: got v=%b y=%h t=%h il=%b rdy=%b expected 0/0/0/0/1",
                     b_out_valid, b_out_y, b_out_tag, b_out_illegal, b_in_ready);
        else n_pass++;
        n_checks++;
        if ({c_out_valid, c_out_y, c_out_tag, c_out_illegal, c_in_ready} !== {1'b0, 32'h0, 5'h0, 1'b0, 1'b1})
            $display("FAIL reset_c: got v=%b y=%h t=%h il=%b rdy=%b expected 0/0/0/0/1",
                     c_out_valid, c_out_y, c_out_tag, c_out_illegal, c_in_ready);
        else n_pass++;
        n_checks++;
        if ({w_out_valid, w_out_y, w_out_tag, w_out_illegal, w_in_ready} !== {1'b0, 64'h0, 5'h0, 1'b0, 1'b1})
            $display("FAIL reset_w: got v=%b y=%h t=%h il=%b rdy=%b expected 0/0/0/0/1",
                     w_out_valid, w_out_y, w_out_tag, w_out_illegal, w_in_ready);
        else n_pass++;
    endtask

    task automatic test_sgnj_latency();
        do_reset();
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_x1    = 64'h3F800000;
        in_x2    = 64'hC0000000;
        in_tag   = 5'd3;
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1) $display("FAIL sgnj_ready: got %b expected 1", a_in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({a_out_valid, a_out_y, a_out_tag, a_out_illegal} !== {1'b1, 32'hBF800000, 5'd3, 1'b0})
            $display("FAIL sgnj_result: got v=%b y=%h t=%0d il=%b expected 1/bf800000/3/0",
                     a_out_valid, a_out_y, a_out_tag, a_out_illegal);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0) $display("FAIL sgnj_single: got out_valid=%b expected 0", a_out_valid);
        else n_pass++;
    endtask

    task automatic test_op_sweep();
        logic [2:0]  ops   [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
        logic [31:0] exp_y [6] = '{32'hBF800000, 32'hBF800000, 32'h3F800000,
                                   32'h3F800000, 32'hBF800000, 32'hBF800000};
        logic        exp_il[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        in_x1    = 64'hBF800000;
        in_x2    = 64'h40000000;
        in_valid = 1'b1;
        in_op    = ops[0];
        in_tag   = 5'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({a_out_valid, a_out_y, a_out_tag, a_out_illegal} !== {1'b1, exp_y[k], 5'(k), exp_il[k]})
                $display("FAIL sweep_op%0d: got v=%b y=%h t=%0d il=%b expected 1/%h/%0d/%b",
                         ops[k], a_out_valid, a_out_y, a_out_tag, a_out_illegal, exp_y[k], k, exp_il[k]);
            else n_pass++;
            if (k < 5) begin
                in_op  = ops[k+1];
                in_tag = 5'(k + 1);
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [64:0] exp [4];
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            in_tag = 5'(k);
            in_op  = 3'($urandom_range(0, 5));
            in_x1  = {$urandom, $urandom};
            in_x2  = {$urandom, $urandom};
            exp[k] = ref_op(in_op, in_x1, in_x2, 32);
            #1;
            n_checks++;
            if (c_in_ready !== (k < 3)) $display("FAIL bp_ready_%0d: got %b expected %b", k, c_in_ready, k < 3);
            else n_pass++;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({c_in_ready, c_out_valid, c_out_tag} !== {1'b0, 1'b1, 5'd0})
            $display("FAIL bp_full_hold: got rdy=%b v=%b t=%0d expected 0/1/0", c_in_ready, c_out_valid, c_out_tag);
        else n_pass++;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (c_in_ready !== 1'b1) $display("FAIL bp_ready_release: got %b expected 1", c_in_ready);
        else n_pass++;
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if ({c_out_valid, c_out_y, c_out_tag, c_out_illegal} !== {1'b1, exp[j][31:0], 5'(j), exp[j][64]})
                $display("FAIL bp_drain_%0d: got v=%b y=%h t=%0d il=%b expected 1/%h/%0d/%b",
                         j, c_out_valid, c_out_y, c_out_tag, c_out_illegal, exp[j][31:0], j, exp[j][64]);
            else n_pass++;
            @(negedge clk);
            if (j == 0) in_valid = 1'b0;
            #1;
        end
        n_checks++;
        if (c_out_valid !== 1'b0) $display("FAIL bp_empty: got out_valid=%b expected 0", c_out_valid);
        else n_pass++;
    endtask

    task automatic test_nan64();
        do_reset();
        in_valid = 1'b1;
        in_op    = 3'd4;
        in_x1    = 64'h7FF8000000000001;
        in_x2    = {$urandom, $urandom};
        in_tag   = 5'd17;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_checks++;
            if (w_out_valid !== (c == 4)) $display("FAIL nan64_lat_%0d: got out_valid=%b expected %b", c, w_out_valid, c == 4);
            else n_pass++;
            if (c < 4) @(negedge clk);
        end
        n_checks++;
        if ({w_out_y, w_out_tag, w_out_illegal} !== {64'hFFF8000000000001, 5'd17, 1'b0})
            $display("FAIL nan64_result: got y=%h t=%0d il=%b expected fff8000000000001/17/0",
                     w_out_y, w_out_tag, w_out_illegal);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [64:0] exp5;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd2;
        in_x1     = 64'h12345678;
        in_x2     = 64'h87654321;
        in_tag    = 5'd1;
        @(negedge clk);
        in_tag = 5'd2;
        @(negedge clk);
        in_tag = 5'd9;
        flush  = 1'b1;
        #1;
        n_checks++;
        if ({b_in_ready, b_out_valid, b_out_tag} !== {1'b0, 1'b1, 5'd1})
            $display("FAIL flush_cycle: got rdy=%b v=%b t=%0d expected 0/1/1", b_in_ready, b_out_valid, b_out_tag);
        else n_pass++;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b1;
        in_tag    = 5'd5;
        in_op     = 3'd1;
        in_x1     = {$urandom, $urandom};
        in_x2     = {$urandom, $urandom};
        exp5      = ref_op(in_op, in_x1, in_x2, 32);
        #1;
        n_checks++;
        if ({b_out_valid, b_in_ready} !== 2'b01)
            $display("FAIL flush_cleared: got v=%b rdy=%b expected 0/1", b_out_valid, b_in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (b_out_valid !== 1'b0) $display("FAIL flush_reissue_lat: got out_valid=%b expected 0", b_out_valid);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if ({b_out_valid, b_out_y, b_out_tag, b_out_illegal} !== {1'b1, exp5[31:0], 5'd5, exp5[64]})
            $display("FAIL flush_reissue: got v=%b y=%h t=%0d il=%b expected 1/%h/5/%b",
                     b_out_valid, b_out_y, b_out_tag, b_out_illegal, exp5[31:0], exp5[64]);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (b_out_valid !== 1'b0) $display("FAIL flush_no_stale: got out_valid=%b t=%0d expected 0", b_out_valid, b_out_tag);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd5;
        for (int k = 0; k < 4; k++) begin
            in_tag = 5'(k + 20);
            in_x1  = {$urandom, $urandom} | 64'h1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({c_out_valid, c_out_y, c_out_tag, c_out_illegal, c_in_ready} !== {1'b0, 32'h0, 5'h0, 1'b0, 1'b1})
            $display("FAIL rst_mid: got v=%b y=%h t=%0d il=%b rdy=%b expected 0/0/0/0/1",
                     c_out_valid, c_out_y, c_out_tag, c_out_illegal, c_in_ready);
        else n_pass++;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (c_out_valid !== 1'b0) $display("FAIL rst_mid_stale_%0d: got out_valid=%b t=%0d expected 0", k, c_out_valid, c_out_tag);
            else n_pass++;
        end
    endtask

    typedef struct packed {
        logic        ill;
        logic [31:0] y;
        logic [4:0]  tag;
    } exp_t;

    task automatic test_random();
        exp_t        q[$];
        exp_t        got, prev;
        exp_t        e;
        logic [64:0] r;
        logic        acc, del, exp_rdy, prev_stall;
        do_reset();
        prev_stall = 1'b0;
        prev       = '0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc < 600) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
                flush     = ($urandom_range(0, 99) < 3);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
                flush     = 1'b0;
            end
            in_op  = 3'($urandom_range(0, 7));
            in_x1  = {$urandom, $urandom};
            in_x2  = {$urandom, $urandom};
            in_tag = 5'($urandom);
            #1;
            got     = '{ill: c_out_illegal, y: c_out_y, tag: c_out_tag};
            exp_rdy = !flush && !(q.size() == 3 && !out_ready);
            n_checks++;
            if (c_in_ready !== exp_rdy)
                $display("FAIL rnd_ready@%0d: got %b expected %b (occ=%0d)", cyc, c_in_ready, exp_rdy, q.size());
            else n_pass++;
            if (prev_stall) begin
                n_checks++;
                if (c_out_valid !== 1'b1 || got !== prev)
                    $display("FAIL rnd_hold@%0d: got v=%b %h expected 1 %h", cyc, c_out_valid, got, prev);
                else n_pass++;
            end
            acc = in_valid && c_in_ready;
            del = c_out_valid && out_ready;
            if (del) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL rnd_spurious@%0d: got result %h expected none", cyc, got);
                end else begin
                    if (got !== q[0]) $display("FAIL rnd_data@%0d: got %h expected %h", cyc, got, q[0]);
                    else n_pass++;
                end
            end
            prev_stall = c_out_valid && !out_ready && !flush;
            prev       = got;
            r          = ref_op(in_op, in_x1, in_x2, 32);
            e          = '{ill: r[64], y: r[31:0], tag: in_tag};
            @(posedge clk);
            if (del && q.size() > 0) void'(q.pop_front());
            if (flush) q.delete();
            else if (acc) q.push_back(e);
        end
        n_checks++;
        if (q.size() != 0) $display("FAIL rnd_drain: got %0d outstanding expected 0", q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sgnj_latency();
        test_op_sweep();
        test_back_to_back();
        test_nan64();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fsign_pipe.md
Name: fsign_pipe

Overview:
- Parametrised, pipelined sign-manipulation unit. Covers FSGNJ, FSGNJN, FSGNJX, FABS, FNEG and FMV behind one opcode.
- Uses valid/ready handshakes on both sides, with full backpressure, bubble collapsing and flush.
- Sits in the FPU execute cluster beside the arithmetic units and supports single or double precision through FLEN.
- Returns a caller tag so the issue logic can match results to requests.

Parameters:
- FLEN, 32, operand width in bits (32 or 64); the sign bit is bit FLEN-1.
- STAGES, 1, number of register stages (1..4); this is the latency with no stall.
- TAGW, 5, width of the passthrough tag (destination register index).

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all in-flight operations.
- in_valid  in  1  request is present.
- in_ready  out  1  unit accepts a request this cycle.
- in_op  in  3  operation select.
- in_x1  in  FLEN  operand 1 (magnitude source).
- in_x2  in  FLEN  operand 2 (sign source).
- in_tag  in  TAGW  caller tag.
- out_valid  out  1  result is present.
- out_ready  in  1  consumer accepts the result.
- out_y  out  FLEN  result.
- out_tag  out  TAGW  tag of the result.
- out_illegal  out  1  the op code was unassigned.

Behaviour:
- Opcodes (S = FLEN-1, M = x1[S-1:0]):
  - 000 SGNJ: {x2[S], M}
  - 001 SGNJN: {~x2[S], M}
  - 010 SGNJX: {x1[S]^x2[S], M}
  - 011 ABS: {0, M}
  - 100 NEG: {~x1[S], M}
  - 101 MOV: x1
  - 110/111: result x1, illegal=1
- The magnitude always comes from x1. Exponent, mantissa and NaN payloads pass bit-exact; NaNs are not canonicalised.
- The result is computed combinationally from the inputs and captured into stage 0. Later stages only move data forward.
- Each stage holds valid, y, tag and illegal.
- Advance rule:
  - The last stage advances when it is empty or when out_ready=1.
  - Stage i advances when it is empty or stage i+1 advances.
  - A stage that advances loads from stage i-1, or from the inputs for stage 0.
  - An empty stage always accepts, so bubbles collapse.
- in_ready is combinational: stage 0 advances and flush=0. There is no combinational path from in_valid to in_ready.
- A transfer happens on in_valid & in_ready. If in_valid=0, stage 0 loads valid=0.
- out_valid, out_y, out_tag and out_illegal come from the last stage. While out_valid & ~out_ready, all four outputs hold stable.
- Latency is STAGES cycles from accept to out_valid with no stall. Throughput is one operation per cycle under continuous out_ready.
- Full condition: all stages valid and out_ready=0. Then in_ready=0 and nothing moves.
- Simultaneous events:
  - If the last stage drains while a new input enters, both happen in the same cycle.
  - Occupancy never exceeds STAGES.
- Flush:
  - All valid bits clear on the next edge.
  - The same-cycle input is not accepted (in_ready=0).
  - The output handshake in that cycle still completes if out_ready=1. The consumer must treat a result presented alongside flush as accepted only if it itself sampled out_ready=1.
  - Data registers are not cleared by flush.
- Reset: all valid bits, y, tag and illegal are 0. Outputs after reset are out_valid=0, out_y=0, out_tag=0, out_illegal=0 and in_ready=1. Reset takes priority over flush and handshakes, and an operation in flight when reset is asserted is lost.

Test Plan:
- FLEN=32, STAGES=1: SGNJ x1=0x3F800000, x2=0xC0000000, tag=3 -> one cycle later out_y=0xBF800000, out_tag=3, out_illegal=0.
- Full op sweep, x1=0xBF800000, x2=0x40000000: SGNJN gives 0xBF800000, SGNJX gives 0xBF800000, ABS gives 0x3F800000, NEG gives 0x3F800000, MOV gives 0xBF800000. op=111 gives 0xBF800000 with out_illegal=1.
- STAGES=3 with out_ready=0: issue 4 back-to-back ops -> 3 are accepted and in_ready drops to 0. Raise out_ready -> results drain in order, one per cycle, with tags 0,1,2,3 and no loss.
- FLEN=64: NEG of x1=0x7FF8000000000001 (NaN) -> 0xFFF8000000000001, with the payload unchanged.
- STAGES=2 with 2 ops in flight: pulse flush for one cycle -> out_valid=0 on the following cycle. An op issued the next cycle emerges normally 2 cycles later.
- Assert rst mid-stream with the pipeline full -> the next cycle shows out_valid=0, out_y=0, in_ready=1. No stale result ever appears.
